// File: rtl/quickq_pkg.sv
// Shared types and defaults for the QuickQ heap controller.
package quickq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 15;
  localparam int IDX_W_DEF  = 32;

  // Heap is 1-indexed: the root lives at slot 1, slot 0 is never used.
  localparam int ROOT_IDX = 1;

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DOWN,
    DONE
  } state_t;

  // Which of node/left/right holds the smallest key.
  typedef enum logic [1:0] {
    SEL_NODE,
    SEL_LEFT,
    SEL_RIGHT
  } sel_t;

endpackage

// File: rtl/quickq_heap_ctrl_if.sv
// Enqueue/dequeue handshake and queue status bundle.
interface quickq_heap_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 32
);
  logic              enq_req;
  logic [DATA_W-1:0] enq_data;
  logic              deq_req;
  logic              enq_ack;
  logic              deq_ack;
  logic [DATA_W-1:0] deq_data;
  logic [DATA_W-1:0] min_data;
  logic [IDX_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              busy;
  logic              done;

  modport master (
    output enq_req, enq_data, deq_req,
    input  enq_ack, deq_ack, deq_data, min_data, count, full, empty, busy, done
  );

  modport slave (
    input  enq_req, enq_data, deq_req,
    output enq_ack, deq_ack, deq_data, min_data, count, full, empty, busy, done
  );
endinterface

// File: rtl/quickq_heap_ctrl_min3.sv
// Picks the smallest of a heap node and its existing children.
// Strict less-than: ties keep the node, and left wins a tie against right.
module heap_min3
  import quickq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_node,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_l_ex,
  input  logic              i_r_ex,
  output sel_t              o_sel
);
  logic [DATA_W-1:0] w_best;

  // Running minimum over node, then left, then right.
  always_comb begin
    o_sel  = SEL_NODE;
    w_best = i_node;
    if (i_l_ex && (i_left < w_best)) begin
      o_sel  = SEL_LEFT;
      w_best = i_left;
    end
    if (i_r_ex && (i_right < w_best)) begin
      o_sel  = SEL_RIGHT;
      w_best = i_right;
    end
  end
endmodule

// File: rtl/quickq_heap_ctrl.sv
// QuickQ min-heap control/storage: key array, count, handshake and the
// sift FSM. The heap index lives in an external pointer counter that this
// block commands; its registered value returns on ptr_in one cycle later.
module quickq_heap_ctrl
  import quickq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  quickq_heap_ctrl_if.slave q,
  output logic              ptr_rst,
  output logic              ptr_ld,
  output logic              ptr_clr,
  output logic              ptr_inc,
  output logic              ptr_decr,
  output logic              ptr_two,
  output logic [IDX_W-1:0]  ptr_base,
  output logic [IDX_W-1:0]  last_index,
  input  logic [IDX_W-1:0]  ptr_in
);
  // Array address width; slot 0 exists but is never used.
  localparam int AW = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] ROOT = IDX_W'(ROOT_IDX);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_count, w_count_nxt;
  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_deq_data;
  logic              r_enq_ack, r_deq_ack, r_done, r_ptr_rst;

  logic              w_enq_acc, w_deq_acc;
  logic              w_wa_en, w_wb_en;
  logic [AW-1:0]     w_wa_addr, w_wb_addr;
  logic [DATA_W-1:0] w_wa_data, w_wb_data;

  logic [IDX_W-1:0]  w_i, w_p, w_l, w_r, w_cnt_inc;
  logic [DATA_W-1:0] w_key_i, w_key_p, w_key_l, w_key_r, w_key_last;
  logic              w_l_ex, w_r_ex, w_full, w_empty;
  sel_t              w_sel;

  assign w_i       = ptr_in;
  assign w_p       = w_i >> 1;
  assign w_l       = w_i << 1;
  assign w_r       = w_l + IDX_W'(1);
  assign w_cnt_inc = r_count + IDX_W'(1);
  // Children beyond count may alias other slots after truncation; the
  // existence flags keep them out of the comparison.
  assign w_l_ex     = (w_l <= r_count);
  assign w_r_ex     = (w_r <= r_count);
  assign w_key_i    = r_mem[w_i[AW-1:0]];
  assign w_key_p    = r_mem[w_p[AW-1:0]];
  assign w_key_l    = r_mem[w_l[AW-1:0]];
  assign w_key_r    = r_mem[w_r[AW-1:0]];
  assign w_key_last = r_mem[r_count[AW-1:0]];
  assign w_full     = (r_count == IDX_W'(DEPTH));
  assign w_empty    = (r_count == '0);

  heap_min3 #(.DATA_W(DATA_W)) u_min3 (
    .i_node (w_key_i),
    .i_left (w_key_l),
    .i_right(w_key_r),
    .i_l_ex (w_l_ex),
    .i_r_ex (w_r_ex),
    .o_sel  (w_sel)
  );

  // Next-state, array write ports and pointer commands.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_enq_acc   = 1'b0;
    w_deq_acc   = 1'b0;
    w_wa_en     = 1'b0;
    w_wa_addr   = '0;
    w_wa_data   = '0;
    w_wb_en     = 1'b0;
    w_wb_addr   = '0;
    w_wb_data   = '0;
    ptr_ld      = 1'b0;
    ptr_clr     = 1'b0;
    ptr_inc     = 1'b0;
    ptr_base    = '0;
    unique case (r_state)
      IDLE: begin
        // Nothing is accepted while the pointer counter is still clearing.
        if (!r_ptr_rst) begin
          if (q.deq_req && !w_empty) begin
            w_deq_acc   = 1'b1;
            w_wa_en     = 1'b1;
            w_wa_addr   = ROOT[AW-1:0];
            w_wa_data   = w_key_last;
            w_count_nxt = r_count - IDX_W'(1);
            if (r_count == ROOT) begin
              ptr_clr     = 1'b1;
              w_state_nxt = DONE;
            end else begin
              ptr_ld      = 1'b1;
              w_state_nxt = SIFT_DOWN;
            end
          end else if (q.enq_req && !w_full) begin
            w_enq_acc   = 1'b1;
            w_wa_en     = 1'b1;
            w_wa_addr   = w_cnt_inc[AW-1:0];
            w_wa_data   = q.enq_data;
            w_count_nxt = w_cnt_inc;
            ptr_base    = r_count;
            ptr_inc     = 1'b1;
            w_state_nxt = SIFT_UP;
          end
        end
      end
      SIFT_UP: begin
        if ((w_i == ROOT) || (w_key_p <= w_key_i)) begin
          ptr_clr     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_wa_en   = 1'b1;
          w_wa_addr = w_i[AW-1:0];
          w_wa_data = w_key_p;
          w_wb_en   = 1'b1;
          w_wb_addr = w_p[AW-1:0];
          w_wb_data = w_key_i;
          ptr_base  = w_p;
        end
      end
      SIFT_DOWN: begin
        if ((w_sel == SEL_NODE) || !w_l_ex) begin
          ptr_clr     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_wa_en   = 1'b1;
          w_wa_addr = w_i[AW-1:0];
          w_wb_en   = 1'b1;
          w_wb_data = w_key_i;
          ptr_base  = w_l;
          if (w_sel == SEL_LEFT) begin
            w_wa_data = w_key_l;
            w_wb_addr = w_l[AW-1:0];
          end else begin
            w_wa_data = w_key_r;
            w_wb_addr = w_r[AW-1:0];
            ptr_inc   = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Key array: two write ports cover a swap in a single cycle.
  always_ff @(posedge clk) begin
    if (w_wa_en) r_mem[w_wa_addr] <= w_wa_data;
    if (w_wb_en) r_mem[w_wb_addr] <= w_wb_data;
  end

  // Control registers, handshake pulses and pointer-counter reset request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_deq_data <= '0;
      r_enq_ack  <= 1'b0;
      r_deq_ack  <= 1'b0;
      r_done     <= 1'b0;
      r_ptr_rst  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_enq_ack <= w_enq_acc;
      r_deq_ack <= w_deq_acc;
      r_done    <= (w_state_nxt == DONE);
      r_ptr_rst <= 1'b0;
      if (w_deq_acc) r_deq_data <= r_mem[ROOT_IDX];
    end
  end

  assign q.enq_ack  = r_enq_ack;
  assign q.deq_ack  = r_deq_ack;
  assign q.deq_data = r_deq_data;
  assign q.min_data = w_empty ? '0 : r_mem[ROOT_IDX];
  assign q.count    = r_count;
  assign q.full     = w_full;
  assign q.empty    = w_empty;
  assign q.busy     = (r_state != IDLE);
  assign q.done     = r_done;
  assign ptr_rst    = r_ptr_rst;
  assign ptr_decr   = 1'b0;
  assign ptr_two    = 1'b0;
  assign last_index = r_count;
endmodule

// File: tb/tb_quickq_heap_ctrl.sv
// Scoreboard bench for quickq_heap_ctrl with an external pointer counter.
module tb_quickq_heap_ctrl;
  localparam int DW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  quickq_heap_ctrl_if #(.DATA_W(DW), .IDX_W(IW)) qif ();

  logic          ptr_rst, ptr_ld, ptr_clr, ptr_inc, ptr_decr, ptr_two;
  logic [IW-1:0] ptr_base, last_index, ptr_in;

  quickq_heap_ctrl #(.DATA_W(DW), .DEPTH(15), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (qif.slave),
    .ptr_rst   (ptr_rst),
    .ptr_ld    (ptr_ld),
    .ptr_clr   (ptr_clr),
    .ptr_inc   (ptr_inc),
    .ptr_decr  (ptr_decr),
    .ptr_two   (ptr_two),
    .ptr_base  (ptr_base),
    .last_index(last_index),
    .ptr_in    (ptr_in)
  );

  // Downstream array pointer counter (synchronous reset).
  always @(posedge clk) begin
    if (ptr_rst)      ptr_in <= '0;
    else if (ptr_ld)  ptr_in <= 1;
    else if (ptr_clr) ptr_in <= '0;
    else if (ptr_inc) ptr_in <= ptr_base + 1;
    else              ptr_in <= ptr_base;
  end

  typedef struct {
    logic [31:0] mn;
    logic [31:0] cnt;
  } done_t;

  done_t       exp_done[$];
  logic [31:0] exp_deq[$];
  int vec = 0;
  int nerr = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    vec++;
    nerr++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", nm, $time);
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return qif.enq_ack;
      1:       return qif.deq_ack;
      default: return qif.done;
    endcase
  endfunction

  // Wait (bounded) at negedges for enq_ack(0) / deq_ack(1) / done(2).
  task automatic wait_sig(input string nm, input int which, input bit now, output bit got);
    got = 1'b0;
    if (now && sig(which)) begin
      got = 1'b1;
      return;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (sig(which)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) tmo(nm);
  endtask

  // Count negedges from the current one until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!qif.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!qif.done) begin
      tmo("done");
      lat = -1;
    end
  endtask

  task automatic do_enq(input logic [31:0] k, input logic [31:0] mn,
                        input logic [31:0] cnt, output int lat);
    bit got;
    exp_done.push_back('{mn, cnt});
    @(negedge clk);
    qif.enq_data = k;
    qif.enq_req  = 1'b1;
    wait_sig("enq_ack", 0, 1'b0, got);
    qif.enq_req = 1'b0;
    lat = -1;
    if (got) wait_done(lat);
  endtask

  task automatic do_deq(input logic [31:0] d, input logic [31:0] mn,
                        input logic [31:0] cnt, output int lat);
    bit got;
    exp_deq.push_back(d);
    exp_done.push_back('{mn, cnt});
    @(negedge clk);
    qif.deq_req = 1'b1;
    wait_sig("deq_ack", 1, 1'b0, got);
    qif.deq_req = 1'b0;
    lat = -1;
    if (got) wait_done(lat);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (qif.deq_ack) begin
        if (exp_deq.size() == 0) begin
          vec++; nerr++;
          $display("FAIL deq_unexpected actual=%0d required=none", qif.deq_data);
        end else begin
          chk("deq_data", qif.deq_data, exp_deq.pop_front());
        end
      end
      if (qif.done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          vec++; nerr++;
          $display("FAIL done_unexpected actual=%0d required=none", qif.count);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_min", qif.min_data, d.mn);
          chk("done_count", qif.count, d.cnt);
          chk("done_last_index", last_index, d.cnt);
        end
      end
      chk("ptr_reserved", {30'd0, ptr_decr, ptr_two}, 32'd0);
      if (qif.busy && !qif.done)
        chk("ptr_in_range", {31'd0, (ptr_in >= 1) && (ptr_in <= qif.count)}, 32'd1);
    end
  end

  task automatic reset_release();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ptr_rst_held", {31'd0, ptr_rst}, 32'd1);
    @(negedge clk);
    chk("ptr_rst_release", {31'd0, ptr_rst}, 32'd0);
  endtask

  initial begin
    int lat;
    bit got;
    int nd0;
    rst_n        = 1'b0;
    qif.enq_req  = 1'b0;
    qif.deq_req  = 1'b0;
    qif.enq_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_count", qif.count, 0);
    chk("rst_empty", {31'd0, qif.empty}, 1);
    chk("rst_full", {31'd0, qif.full}, 0);
    chk("rst_busy", {31'd0, qif.busy}, 0);
    chk("rst_ptr_rst", {31'd0, ptr_rst}, 1);
    chk("rst_deq_data", qif.deq_data, 0);
    chk("rst_min", qif.min_data, 0);
    chk("rst_cmds", {29'd0, ptr_ld, ptr_clr, ptr_inc}, 0);
    chk("rst_ptr_base", ptr_base, 0);
    chk("rst_pulses", {29'd0, qif.enq_ack, qif.deq_ack, qif.done}, 0);
    reset_release();

    // Enqueue 5,3,8,1
    do_enq(5, 5, 1, lat); chk("lat_enq5", lat, 1);
    do_enq(3, 3, 2, lat); chk("lat_enq3", lat, 2);
    do_enq(8, 3, 3, lat); chk("lat_enq8", lat, 1);
    do_enq(1, 1, 4, lat); chk("lat_enq1", lat, 3);
    chk("count4", qif.count, 4);

    // Four dequeues
    do_deq(1, 3, 3, lat);
    do_deq(3, 5, 2, lat);
    do_deq(5, 8, 1, lat); chk("lat_deq_cnt2", lat, 1);
    do_deq(8, 0, 0, lat); chk("lat_deq_cnt1", lat, 0);
    chk("empty_after_drain", {31'd0, qif.empty}, 1);

    // Dequeue on empty is held off
    @(negedge clk);
    qif.deq_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("empty_hold_ack", {30'd0, qif.deq_ack, qif.busy}, 0);
    end
    qif.deq_req = 1'b0;

    // Fill with 15..1
    for (int k = 15; k >= 1; k--) do_enq(k, k, 16 - k, lat);
    chk("full", {31'd0, qif.full}, 1);
    chk("full_min", qif.min_data, 1);

    // 16th enqueue held, then released by a dequeue
    @(negedge clk);
    qif.enq_data = 20;
    qif.enq_req  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("full_hold_ack", {31'd0, qif.enq_ack}, 0);
      chk("full_hold_count", qif.count, 15);
    end
    exp_deq.push_back(1);
    exp_done.push_back('{32'd2, 32'd14});
    exp_done.push_back('{32'd2, 32'd15});
    qif.deq_req = 1'b1;
    wait_sig("pend_deq_ack", 1, 1'b0, got);
    chk("pend_no_enq_ack", {31'd0, qif.enq_ack}, 0);
    qif.deq_req = 1'b0;
    nd0 = n_done;
    wait_sig("pend_enq_ack", 0, 1'b0, got);
    chk("pend_enq_after_done", n_done - nd0, 1);
    qif.enq_req = 1'b0;
    if (got) wait_done(lat);
    chk("refull", {31'd0, qif.full}, 1);

    // Reset in the middle of a sift-down
    exp_deq.push_back(2);
    @(negedge clk);
    qif.deq_req = 1'b1;
    wait_sig("rst_deq_ack", 1, 1'b0, got);
    qif.deq_req = 1'b0;
    chk("mid_sift_busy", {30'd0, qif.busy, qif.done}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    exp_done.delete();
    chk("midrst_count", qif.count, 0);
    chk("midrst_empty", {31'd0, qif.empty}, 1);
    chk("midrst_busy", {31'd0, qif.busy}, 0);
    chk("midrst_ptr_rst", {31'd0, ptr_rst}, 1);
    repeat (2) @(negedge clk);
    reset_release();

    // Duplicate keys: tie does not swap
    do_enq(4, 4, 1, lat); chk("lat_dup1", lat, 1);
    do_enq(4, 4, 2, lat); chk("lat_dup2", lat, 1);

    // Simultaneous enq/deq: dequeue first, enqueue after done
    exp_deq.push_back(4);
    exp_done.push_back('{32'd4, 32'd1});
    exp_done.push_back('{32'd4, 32'd2});
    @(negedge clk);
    qif.enq_data = 7;
    qif.enq_req  = 1'b1;
    qif.deq_req  = 1'b1;
    wait_sig("sim_deq_ack", 1, 1'b0, got);
    chk("sim_no_enq_ack", {31'd0, qif.enq_ack}, 0);
    qif.deq_req = 1'b0;
    nd0 = n_done;
    wait_sig("sim_enq_ack", 0, 1'b0, got);
    chk("sim_enq_after_done", n_done - nd0, 1);
    qif.enq_req = 1'b0;
    if (got) wait_done(lat);

    do_deq(4, 7, 1, lat);
    do_deq(7, 0, 0, lat);
    chk("final_empty", {31'd0, qif.empty}, 1);
    @(negedge clk);
    chk("scoreboard_drained", exp_deq.size() + exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
